// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared playfield constants, row/board types and board state enum
package tetris_pkg;

  localparam int ROWS = 22;
  localparam int COLS = 10;
  localparam int RW   = 5;

  typedef logic [COLS-1:0] row_t;
  typedef row_t [ROWS-1:0] board_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } board_state_e;

endpackage

// File: rtl/playfield_board_if.sv
// rtl/playfield_board_if.sv - game-logic FSM to playfield board bus
interface playfield_board_if;
  import tetris_pkg::*;

  logic            shift_req;
  logic [RW-1:0]   shift_row;
  logic            wr_en;
  logic [RW-1:0]   wr_row;
  logic [COLS-1:0] wr_mask;
  logic [RW-1:0]   probe_row;
  logic [COLS-1:0] probe_mask;
  logic [RW-1:0]   rd_row;
  logic            busy;
  logic            shift_done;
  logic [ROWS-1:0] full_rows;
  logic [COLS-1:0] collision;
  logic            overflow;
  logic [COLS-1:0] rd_data;

  modport master (
    output shift_req, shift_row, wr_en, wr_row, wr_mask, probe_row, probe_mask, rd_row,
    input  busy, shift_done, full_rows, collision, overflow, rd_data
  );

  modport slave (
    input  shift_req, shift_row, wr_en, wr_row, wr_mask, probe_row, probe_mask, rd_row,
    output busy, shift_done, full_rows, collision, overflow, rd_data
  );

endinterface

// File: rtl/playfield_board_row_full_detect.sv
// rtl/playfield_board_row_full_detect.sv - per-row AND-reduce giving the full-row vector
module row_full_detect
  import tetris_pkg::*;
(
  input  board_t          board,
  output logic [ROWS-1:0] full
);

  // A row is full when every one of its cells is set
  always_comb begin
    full = '0;
    for (int r = 0; r < ROWS; r++) begin
      full[r] = &board[r];
    end
  end

endmodule

// File: rtl/playfield_board.sv
// rtl/playfield_board.sv - playfield storage, row-shift FSM, status and display read (optional PLAYFIELD_LINE_COUNT_EN)
module playfield_board
  import tetris_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  playfield_board_if.slave   bus
`ifdef PLAYFIELD_LINE_COUNT_EN
  ,
  output logic [15:0]        lines_cleared
`endif
);

  localparam logic [RW-1:0] ROW_LIMIT = RW'(ROWS);

  board_t          board;
  board_state_e    state;
  logic [RW-1:0]   idx;
  logic [ROWS-1:0] full_next;

  row_full_detect u_row_full_detect (
    .board (board),
    .full  (full_next)
  );

  // Board storage and shift FSM; a shift request outranks a same-cycle write
  always_ff @(posedge clk) begin
    if (!reset) begin
      board           <= '0;
      state           <= IDLE;
      idx             <= '0;
      bus.busy        <= 1'b0;
      bus.shift_done  <= 1'b0;
    end else begin
      bus.shift_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.shift_req) begin
            if (bus.shift_row < ROW_LIMIT) begin
              state    <= SHIFT;
              idx      <= bus.shift_row;
              bus.busy <= 1'b1;
            end
          end else if (bus.wr_en && (bus.wr_row < ROW_LIMIT)) begin
            board[bus.wr_row] <= board[bus.wr_row] | bus.wr_mask;
          end
        end
        SHIFT: begin
          if (idx != '0) begin
            board[idx] <= board[idx - RW'(1)];
            idx        <= idx - RW'(1);
          end else begin
            board[0]       <= '0;
            state          <= DONE;
            bus.busy       <= 1'b0;
            bus.shift_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Status and display read, recomputed every cycle from the current board
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.full_rows <= '0;
      bus.collision <= '0;
      bus.overflow  <= 1'b0;
      bus.rd_data   <= '0;
    end else begin
      bus.full_rows <= full_next;
      bus.collision <= (bus.probe_row < ROW_LIMIT) ? (board[bus.probe_row] & bus.probe_mask) : '0;
      bus.overflow  <= (|board[0]) | (|board[1]);
      bus.rd_data   <= (bus.rd_row < ROW_LIMIT) ? board[bus.rd_row] : '0;
    end
  end

`ifdef PLAYFIELD_LINE_COUNT_EN
  // Saturating count of completed shifts
  always_ff @(posedge clk) begin
    if (!reset) begin
      lines_cleared <= '0;
    end else if (bus.shift_done && (lines_cleared != 16'hFFFF)) begin
      lines_cleared <= lines_cleared + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_playfield_board.sv
// tb/tb_playfield_board.sv - randomized self-checking bench for playfield_board
module tb_playfield_board;
  import tetris_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [COLS-1:0] model [ROWS];
  int   exp_lines;

  playfield_board_if bus_if ();

`ifdef PLAYFIELD_LINE_COUNT_EN
  logic [15:0] lines_cleared;
  playfield_board dut (.clk(clk), .reset(reset), .bus(bus_if), .lines_cleared(lines_cleared));
`else
  playfield_board dut (.clk(clk), .reset(reset), .bus(bus_if));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus_if.shift_req  = 1'b0;
    bus_if.shift_row  = '0;
    bus_if.wr_en      = 1'b0;
    bus_if.wr_row     = '0;
    bus_if.wr_mask    = '0;
    bus_if.probe_row  = '0;
    bus_if.probe_mask = '0;
    bus_if.rd_row     = '0;
  endtask

  task automatic clear_model;
    for (int r = 0; r < ROWS; r++) model[r] = '0;
    exp_lines = 0;
  endtask

  task automatic do_write(input int row, input logic [COLS-1:0] mask);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_row  = RW'(row);
    bus_if.wr_mask = mask;
    tick();
    bus_if.wr_en   = 1'b0;
    if (row < ROWS) model[row] = model[row] | mask;
  endtask

  // Remove row r, drop everything above it by one row, clear the top row
  task automatic model_shift(input int r);
    for (int k = r; k > 0; k--) model[k] = model[k-1];
    model[0] = '0;
    exp_lines++;
  endtask

  task automatic do_shift(input int r, input bit junk_write);
    int cnt;
    bus_if.shift_req = 1'b1;
    bus_if.shift_row = RW'(r);
    if (junk_write) begin
      bus_if.wr_en   = 1'b1;
      bus_if.wr_row  = RW'(5);
      bus_if.wr_mask = 10'h3FF;
    end
    tick();
    bus_if.shift_req = 1'b0;
    if (r >= ROWS) begin
      bus_if.wr_en = 1'b0;
      check_val("oor_shift_busy", 32'(bus_if.busy), 32'd0);
      check_val("oor_shift_done", 32'(bus_if.shift_done), 32'd0);
      tick();
      check_val("oor_shift_done2", 32'(bus_if.shift_done), 32'd0);
      return;
    end
    cnt = 0;
    while (bus_if.busy && cnt < 100) begin
      cnt++;
      tick();
    end
    bus_if.wr_en = 1'b0;
    check_val($sformatf("busy_len_r%0d", r), 32'(cnt), 32'(r + 1));
    check_val("shift_done_pulse", 32'(bus_if.shift_done), 32'd1);
    tick();
    check_val("shift_done_clear", 32'(bus_if.shift_done), 32'd0);
    model_shift(r);
`ifdef PLAYFIELD_LINE_COUNT_EN
    check_val("lines_cleared", 32'(lines_cleared), 32'(exp_lines));
`endif
  endtask

  task automatic check_board(input string tag);
    for (int r = 0; r < ROWS; r++) begin
      bus_if.rd_row = RW'(r);
      tick();
      check_val($sformatf("%s_row%0d", tag, r), 32'(bus_if.rd_data), 32'(model[r]));
    end
    bus_if.rd_row = RW'(ROWS + 1);
    tick();
    check_val($sformatf("%s_rd_oor", tag), 32'(bus_if.rd_data), 32'd0);
  endtask

  task automatic check_status(input string tag, input int prow, input logic [COLS-1:0] pmask);
    logic [ROWS-1:0] exp_full;
    logic [COLS-1:0] exp_col;
    bus_if.probe_row  = RW'(prow);
    bus_if.probe_mask = pmask;
    tick();
    for (int r = 0; r < ROWS; r++) exp_full[r] = (model[r] == 10'h3FF);
    exp_col = (prow < ROWS) ? (model[prow] & pmask) : '0;
    check_val({tag, "_full"}, 32'(bus_if.full_rows), 32'(exp_full));
    check_val({tag, "_ovf"}, 32'(bus_if.overflow), 32'((model[0] != 0) || (model[1] != 0)));
    check_val({tag, "_col"}, 32'(bus_if.collision), 32'(exp_col));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_model();

    // Reset with stimulus held active
    reset = 1'b0;
    bus_if.shift_req  = 1'b1;
    bus_if.shift_row  = RW'(3);
    bus_if.wr_en      = 1'b1;
    bus_if.wr_row     = RW'(21);
    bus_if.wr_mask    = 10'h3FF;
    bus_if.probe_row  = RW'(21);
    bus_if.probe_mask = 10'h3FF;
    bus_if.rd_row     = RW'(21);
    tick();
    tick();
    check_val("rst_busy", 32'(bus_if.busy), 32'd0);
    check_val("rst_done", 32'(bus_if.shift_done), 32'd0);
    check_val("rst_full", 32'(bus_if.full_rows), 32'd0);
    check_val("rst_col", 32'(bus_if.collision), 32'd0);
    check_val("rst_ovf", 32'(bus_if.overflow), 32'd0);
    check_val("rst_rd", 32'(bus_if.rd_data), 32'd0);
`ifdef PLAYFIELD_LINE_COUNT_EN
    check_val("rst_lines", 32'(lines_cleared), 32'd0);
`endif
    idle_inputs();
    reset = 1'b1;
    tick();
    check_board("post_rst");

    // Full bottom row and collision probe
    do_write(21, 10'h3FF);
    check_status("row21_full", 21, 10'h010);

    // Shift the bottom row out
    do_write(20, 10'h001);
    do_write(0, 10'h3FF);
    do_shift(21, 1'b0);
    check_board("shift21");
    check_status("shift21", 1, 10'h3FF);

    // Top-row shift and an out-of-range shift
    do_write(0, 10'h155);
    do_shift(0, 1'b0);
    check_board("shift0");
    do_shift(22, 1'b0);
    check_board("shift22");

    // Writes during busy and alongside shift_req are dropped
    do_shift(4, 1'b1);
    check_board("junk_write");
    do_write(5, 10'h00F);
    do_write(5, 10'h0F0);
    bus_if.rd_row = RW'(5);
    tick();
    check_val("row5_or", 32'(bus_if.rd_data), 32'h0FF);
    do_write(23, 10'h3FF);
    check_board("oor_write");

    // Reset during a row-15 shift
    do_write(14, 10'h3FF);
    bus_if.shift_req = 1'b1;
    bus_if.shift_row = RW'(15);
    tick();
    bus_if.shift_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    clear_model();
    check_val("midrst_busy", 32'(bus_if.busy), 32'd0);
    check_val("midrst_done", 32'(bus_if.shift_done), 32'd0);
    tick();
    check_val("midrst_done2", 32'(bus_if.shift_done), 32'd0);
    check_board("midrst");
    check_status("midrst", 14, 10'h3FF);

    // Three completed shifts from reset
    for (int k = 0; k < 3; k++) begin
      do_write(21, 10'h3FF);
      do_shift(21, 1'b0);
    end
`ifdef PLAYFIELD_LINE_COUNT_EN
    check_val("lines3", 32'(lines_cleared), 32'd3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    clear_model();
    check_val("lines_rst", 32'(lines_cleared), 32'd0);
`endif

    // Randomized writes, shifts and probes against the model
    for (int it = 0; it < 60; it++) begin
      int op;
      int row;
      logic [COLS-1:0] mask;
      op   = $urandom_range(9, 0);
      row  = $urandom_range(ROWS + 1, 0);
      mask = ($urandom_range(3, 0) == 0) ? 10'h3FF : COLS'($urandom);
      if (op < 7) do_write(row, mask);
      else do_shift(row, op[0]);
      check_status($sformatf("rnd%0d", it), $urandom_range(ROWS + 1, 0), COLS'($urandom));
      if (it % 15 == 14) check_board($sformatf("rndb%0d", it));
    end
    check_board("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
